// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial two's-complement adder/subtractor. One full-adder
//                cell and a carry flip-flop produce one result bit per clock,
//                LSB first. Start/busy/done handshake; sum, carry-out and
//                signed overflow are held until the next result completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Counter must hold 0..WIDTH-1; derived here so it cannot be overridden.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    // Only the upper WIDTH-1 result bits need storage: the final bit is
    // produced combinationally on the last RUN cycle and goes straight to sum.
    logic [WIDTH-2:0] r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;

    logic             w_sum_bit;
    logic             w_carry_nxt;
    logic [WIDTH-1:0] w_res_nxt;

    // Single full-adder cell operating on the current LSBs.
    assign w_sum_bit   = r_op_a[0] ^ r_op_b[0] ^ r_carry;
    assign w_carry_nxt = (r_op_a[0] & r_op_b[0]) |
                         (r_op_a[0] & r_carry)   |
                         (r_op_b[0] & r_carry);
    assign w_res_nxt   = {w_sum_bit, r_res};

    // Control FSM, serial datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert B, seed carry with 1.
                        r_op_a  <= a;
                        r_op_b  <= sub ? ~b : b;
                        r_carry <= sub;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_op_a  <= {1'b0, r_op_a[WIDTH-1:1]};
                    r_op_b  <= {1'b0, r_op_b[WIDTH-1:1]};
                    r_res   <= w_res_nxt[WIDTH-1:1];
                    r_carry <= w_carry_nxt;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_last_bit) begin
                        // r_carry is the carry into the MSB on this cycle.
                        sum     <= w_res_nxt;
                        cout    <= w_carry_nxt;
                        ovf     <= r_carry ^ w_carry_nxt;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder at WIDTH=8 and WIDTH=32.
//                Expected results are queued when an operation is launched and
//                compared when done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0, sub8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;
    logic        start32 = 1'b0, sub32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, cout32, ovf32;
    logic [31:0] sum32;

    int total = 0;
    int bad   = 0;
    exp_t q8[$];
    exp_t q32[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(start32), .sub(sub32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .ovf(ovf32)
    );

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] s, input logic c, input logic o);
        exp_t e;
        e.sum = s; e.cout = c; e.ovf = o;
        return e;
    endfunction

    // Reference: wide addition of a + (b or ~b) + sub, masked to w bits.
    function automatic exp_t model(input int w, input logic [63:0] a_v,
                                   input logic [63:0] b_v, input logic s_v);
        logic [64:0] m, full;
        logic [63:0] bb;
        exp_t e;
        m    = (65'd1 << w) - 65'd1;
        bb   = s_v ? ~b_v : b_v;
        full = ({1'b0, a_v} & m) + ({1'b0, bb} & m) + 65'(s_v);
        e.sum  = full[63:0] & m[63:0];
        e.cout = full[w];
        e.ovf  = (a_v[w-1] == bb[w-1]) && (full[w-1] != a_v[w-1]);
        return e;
    endfunction

    // Result scoreboards: one per DUT, popped whenever done pulses.
    always @(negedge clk) begin : mon8
        exp_t e;
        if (done8 === 1'b1) begin
            if (q8.size() == 0) check("unexpected_done8", 66'd1, 66'd0);
            else begin
                e = q8.pop_front();
                check("result8", {56'd0, sum8, cout8, ovf8}, {e.sum, e.cout, e.ovf});
            end
        end
    end

    always @(negedge clk) begin : mon32
        exp_t e;
        if (done32 === 1'b1) begin
            if (q32.size() == 0) check("unexpected_done32", 66'd1, 66'd0);
            else begin
                e = q32.pop_front();
                check("result32", {32'd0, sum32, cout32, ovf32}, {e.sum, e.cout, e.ovf});
            end
        end
    end

    // Counts negedges from just after the accepting edge until done is seen.
    task automatic wait_done(input int w, output int n, output int nb);
        logic d;
        n = 0; nb = 0;
        do begin
            @(negedge clk);
            n++;
            if ((w == 8) ? busy8 : busy32) nb++;
            d = (w == 8) ? done8 : done32;
        end while (!d && n < 200);
        if (!d) begin
            q8.delete();
            q32.delete();
        end
    endtask

    task automatic run_op(input int w, input logic [63:0] a_v, input logic [63:0] b_v,
                          input logic s_v, input exp_t e);
        int n, nb;
        @(posedge clk); #1;
        if (w == 8) begin
            a8 = a_v[7:0]; b8 = b_v[7:0]; sub8 = s_v; start8 = 1'b1; q8.push_back(e);
        end else begin
            a32 = a_v[31:0]; b32 = b_v[31:0]; sub32 = s_v; start32 = 1'b1; q32.push_back(e);
        end
        @(posedge clk); #1;
        // Operands wander during RUN; the result in flight must not notice.
        start8 = 1'b0; start32 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
        a32 = $urandom; b32 = $urandom; sub32 = 1'($urandom);
        wait_done(w, n, nb);
        check("latency", 66'(n), 66'(w + 1));
        check("busy_cycles", 66'(nb), 66'(w));
    endtask

    initial begin
        int n, nb, dn;
        logic [63:0] av, bv;
        logic        sv;
        logic [7:0]  ta [3];
        logic [7:0]  tb [3];
        logic        ts [3];

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset8", {55'd0, busy8, done8, sum8, cout8, ovf8}, 66'd0);
        check("reset32", {31'd0, busy32, done32, sum32, cout32, ovf32}, 66'd0);

        // Directed vectors with hand-computed results
        run_op(8, 64'h35, 64'h4A, 1'b0, mk(64'h7F, 1'b0, 1'b0));
        run_op(8, 64'hFF, 64'h01, 1'b0, mk(64'h00, 1'b1, 1'b0));
        run_op(8, 64'h7F, 64'h01, 1'b0, mk(64'h80, 1'b0, 1'b1));
        run_op(8, 64'h05, 64'h07, 1'b1, mk(64'hFE, 1'b0, 1'b0));
        run_op(8, 64'h80, 64'h01, 1'b1, mk(64'h7F, 1'b1, 1'b1));
        run_op(8, 64'h00, 64'h00, 1'b1, mk(64'h00, 1'b1, 1'b0));
        run_op(32, 64'h7FFF_FFFF, 64'h1, 1'b0, mk(64'h8000_0000, 1'b0, 1'b1));
        run_op(32, 64'h0, 64'h1, 1'b1, mk(64'hFFFF_FFFF, 1'b0, 1'b0));

        // Back-to-back: start held high, a new operand set accepted in each DONE cycle
        ta[0] = 8'h11; tb[0] = 8'h22; ts[0] = 1'b0;
        ta[1] = 8'h90; tb[1] = 8'h90; ts[1] = 1'b0;
        ta[2] = 8'h10; tb[2] = 8'h20; ts[2] = 1'b1;
        @(posedge clk); #1;
        a8 = ta[0]; b8 = tb[0]; sub8 = ts[0]; start8 = 1'b1;
        q8.push_back(model(8, {56'd0, ta[0]}, {56'd0, tb[0]}, ts[0]));
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            if (k < 2) begin
                a8 = ta[k+1]; b8 = tb[k+1]; sub8 = ts[k+1];
                q8.push_back(model(8, {56'd0, ta[k+1]}, {56'd0, tb[k+1]}, ts[k+1]));
            end else begin
                start8 = 1'b0;
            end
            wait_done(8, n, nb);
            check("b2b_latency", 66'(n), 66'd9);
            check("b2b_busy", 66'(nb), 66'd8);
            @(posedge clk); #1;
        end

        // Reset asserted during the 4th RUN cycle aborts the operation
        @(posedge clk); #1;
        a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_outputs", {57'd0, busy8, done8, sum8, cout8, ovf8}, 66'd0);
        dn = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8) dn++;
        end
        check("abort_no_done", 66'(dn), 66'd0);

        // Random regression against the reference model
        for (int i = 0; i < 3000; i++) begin
            av = {$urandom, $urandom}; bv = {$urandom, $urandom}; sv = 1'($urandom_range(0, 1));
            run_op(8, av, bv, sv, model(8, av, bv, sv));
        end
        for (int i = 0; i < 600; i++) begin
            av = {$urandom, $urandom}; bv = {$urandom, $urandom}; sv = 1'($urandom_range(0, 1));
            run_op(32, av, bv, sv, model(32, av, bv, sv));
        end

        repeat (3) @(negedge clk);
        check("queue8_empty", 66'(q8.size()), 66'd0);
        check("queue32_empty", 66'(q32.size()), 66'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
